// File: rtl/adj_matrix_loader.sv
// Edge-list loader for the k-clique finder: builds a symmetric adjacency matrix
// and vertex mask, then holds them until acknowledged. Optional macro: DEGREE_COUNT_EN.
module adj_matrix_loader #(
    parameter int N     = 3,
    parameter int IDX_W = 5,
    parameter int ECW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 edge_valid,
    output logic                 edge_ready,
    input  logic [IDX_W-1:0]     edge_u,
    input  logic [IDX_W-1:0]     edge_v,
    input  logic                 edge_last,
    output logic [N*N-1:0]       adj_matrix,
    output logic [N-1:0]         vertices,
    output logic                 matrix_valid,
    input  logic                 matrix_ack,
    output logic [ECW-1:0]       edge_count,
`ifdef DEGREE_COUNT_EN
    output logic [N*IDX_W-1:0]   degree,
`endif
    output logic                 err_bad_edge
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             edge_ready_r;
    logic             matrix_valid_r;
    logic [N*N-1:0]   adj_r;
    logic [N-1:0]     vertices_r;
    logic [ECW-1:0]   edge_count_r;
    logic             err_r;
    logic             xfer_s;
    logic             bad_s;
    logic             new_s;
    logic [N*N-1:0]   mask_s;
    logic [N-1:0]     vmask_s;

    assign xfer_s = edge_valid & edge_ready_r;

    // Next-state selection for the IDLE/LOAD/HOLD controller
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (xfer_s && edge_last) state_s = ST_HOLD;
                else                     state_s = ST_LOAD;
            end
            ST_HOLD: begin
                if (matrix_ack) state_s = ST_IDLE;
                else            state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            edge_ready_r   <= 1'b0;
            matrix_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            edge_ready_r   <= (state_s == ST_LOAD);
            matrix_valid_r <= (state_s == ST_HOLD);
        end
    end

    // Decode the current beat into symmetric matrix bits and touched vertices
    always_comb begin
        bad_s   = (edge_u >= IDX_W'(N)) || (edge_v >= IDX_W'(N)) || (edge_u == edge_v);
        mask_s  = {(N*N){1'b0}};
        vmask_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            vmask_s[i] = !bad_s && ((edge_u == IDX_W'(i)) || (edge_v == IDX_W'(i)));
            for (int j = 0; j < N; j++) begin
                mask_s[i*N+j] = !bad_s &&
                    (((edge_u == IDX_W'(i)) && (edge_v == IDX_W'(j))) ||
                     ((edge_v == IDX_W'(i)) && (edge_u == IDX_W'(j))));
            end
        end
        // A pair is new only if neither orientation was stored before
        new_s = !bad_s && ((adj_r & mask_s) == {(N*N){1'b0}});
    end

    // Matrix, mask, counter and sticky error; frozen outside LOAD transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_r        <= {(N*N){1'b0}};
            vertices_r   <= {N{1'b0}};
            edge_count_r <= {ECW{1'b0}};
            err_r        <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (start) begin
                adj_r        <= {(N*N){1'b0}};
                vertices_r   <= {N{1'b0}};
                edge_count_r <= {ECW{1'b0}};
                err_r        <= 1'b0;
            end
        end else if ((state_r == ST_LOAD) && xfer_s) begin
            if (bad_s) begin
                err_r <= 1'b1;
            end else begin
                adj_r      <= adj_r | mask_s;
                vertices_r <= vertices_r | vmask_s;
                if (new_s && (edge_count_r != {ECW{1'b1}}))
                    edge_count_r <= edge_count_r + ECW'(1);
            end
        end
    end

`ifdef DEGREE_COUNT_EN
    logic [N-1:0][IDX_W-1:0] degree_r;

    // Per-vertex saturating degree of newly stored edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            degree_r <= {(N*IDX_W){1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (start) degree_r <= {(N*IDX_W){1'b0}};
        end else if ((state_r == ST_LOAD) && xfer_s && new_s) begin
            for (int i = 0; i < N; i++) begin
                if (vmask_s[i] && (degree_r[i] != {IDX_W{1'b1}}))
                    degree_r[i] <= degree_r[i] + IDX_W'(1);
            end
        end
    end

    assign degree = degree_r;
`endif

    assign edge_ready   = edge_ready_r;
    assign matrix_valid = matrix_valid_r;
    assign adj_matrix   = adj_r;
    assign vertices     = vertices_r;
    assign edge_count   = edge_count_r;
    assign err_bad_edge = err_r;

endmodule

// File: tb/tb_adj_matrix_loader.sv
// Self-checking bench for adj_matrix_loader: directed vector table, hand-written
// corner sequences and randomized loads against an adjacency-set reference model.
module tb_adj_matrix_loader;
    localparam int N     = 3;
    localparam int IDX_W = 5;
    localparam int ECW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic edge_valid = 1'b0;
    logic edge_last = 1'b0;
    logic matrix_ack = 1'b0;
    logic [IDX_W-1:0] edge_u = 5'd0;
    logic [IDX_W-1:0] edge_v = 5'd0;
    logic edge_ready;
    logic [N*N-1:0] adj_matrix;
    logic [N-1:0] vertices;
    logic matrix_valid;
    logic [ECW-1:0] edge_count;
    logic err_bad_edge;
`ifdef DEGREE_COUNT_EN
    logic [N*IDX_W-1:0] degree;
`endif

    adj_matrix_loader #(.N(N), .IDX_W(IDX_W), .ECW(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_u(edge_u), .edge_v(edge_v), .edge_last(edge_last),
        .adj_matrix(adj_matrix), .vertices(vertices),
        .matrix_valid(matrix_valid), .matrix_ack(matrix_ack),
        .edge_count(edge_count),
`ifdef DEGREE_COUNT_EN
        .degree(degree),
`endif
        .err_bad_edge(err_bad_edge)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: the set of undirected edges as a boolean matrix
    bit m_adj [N][N];
    int m_cnt;
    bit m_err;
    int m_deg [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_deg[i] = 0;
            for (int j = 0; j < N; j++) m_adj[i][j] = 1'b0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input int u, input int v);
        if (u >= N || v >= N || u == v) begin
            m_err = 1'b1;
        end else begin
            if (!m_adj[u][v]) begin
                if (m_cnt < 3) m_cnt++;
                if (m_deg[u] < 31) m_deg[u]++;
                if (m_deg[v] < 31) m_deg[v]++;
            end
            m_adj[u][v] = 1'b1;
            m_adj[v][u] = 1'b1;
        end
    endtask

    function automatic logic [N*N-1:0] model_adj();
        logic [N*N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) r[i*N+j] = m_adj[i][j];
        return r;
    endfunction

    function automatic logic [N-1:0] model_verts();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) if (m_adj[i][j]) r[i] = 1'b1;
        return r;
    endfunction

    task automatic check_model(input string tag, input logic mv);
        chk({tag, ".adj"}, 32'(adj_matrix), 32'(model_adj()));
        chk({tag, ".vertices"}, 32'(vertices), 32'(model_verts()));
        chk({tag, ".edge_count"}, 32'(edge_count), 32'(m_cnt));
        chk({tag, ".err"}, 32'(err_bad_edge), 32'(m_err));
        chk({tag, ".matrix_valid"}, 32'(matrix_valid), 32'(mv));
`ifdef DEGREE_COUNT_EN
        begin
            logic [N*IDX_W-1:0] d = '0;
            for (int i = 0; i < N; i++) d[i*IDX_W +: IDX_W] = IDX_W'(m_deg[i]);
            chk({tag, ".degree"}, 32'(degree), 32'(d));
        end
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int u, input int v, input bit last, input int gap);
        int n = 0;
        edge_u = IDX_W'(u); edge_v = IDX_W'(v); edge_last = last; edge_valid = 1'b1;
        while (!edge_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!edge_ready) chk("ready_timeout", 32'(edge_ready), 32'd1);
        @(posedge clk); #1;
        edge_valid = 1'b0; edge_last = 1'b0;
        model_edge(u, v);
        for (int g = 0; g < gap; g++) begin
            chk("ready_in_gap", 32'(edge_ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic ack_hold();
        matrix_ack = 1'b1;
        @(posedge clk); #1;
        matrix_ack = 1'b0;
        chk("valid_after_ack", 32'(matrix_valid), 32'd0);
    endtask

    typedef struct {
        logic [14:0] us;
        logic [14:0] vs;
        logic [8:0]  adj;
        logic [2:0]  verts;
        logic [1:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{us: {5'd0, 5'd1, 5'd0}, vs: {5'd2, 5'd2, 5'd1},
                    adj: 9'b011_101_110, verts: 3'b111, cnt: 2'd3, err: 1'b0};
        vecs[1] = '{us: {5'd0, 5'd0, 5'd1}, vs: {5'd1, 5'd5, 5'd1},
                    adj: 9'b000_001_010, verts: 3'b011, cnt: 2'd1, err: 1'b1};
        vecs[2] = '{us: {5'd0, 5'd1, 5'd0}, vs: {5'd1, 5'd0, 5'd1},
                    adj: 9'b000_001_010, verts: 3'b011, cnt: 2'd1, err: 1'b0};

        #2 rst_n = 1'b0;
        #3;
        chk("reset.adj", 32'(adj_matrix), 32'd0);
        chk("reset.vertices", 32'(vertices), 32'd0);
        chk("reset.ready", 32'(edge_ready), 32'd0);
        chk("reset.valid", 32'(matrix_valid), 32'd0);
        chk("reset.count", 32'(edge_count), 32'd0);
        chk("reset.err", 32'(err_bad_edge), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed vector table
        for (int k = 0; k < 3; k++) begin
            model_clear();
            chk("idle.ready", 32'(edge_ready), 32'd0);
            pulse_start();
            chk("load.ready", 32'(edge_ready), 32'd1);
            for (int e = 0; e < 3; e++)
                send(int'(vecs[k].us[e*5 +: 5]), int'(vecs[k].vs[e*5 +: 5]), e == 2, 0);
            chk($sformatf("vec%0d.valid", k), 32'(matrix_valid), 32'd1);
            chk($sformatf("vec%0d.ready", k), 32'(edge_ready), 32'd0);
            chk($sformatf("vec%0d.adj", k), 32'(adj_matrix), 32'(vecs[k].adj));
            chk($sformatf("vec%0d.vertices", k), 32'(vertices), 32'(vecs[k].verts));
            chk($sformatf("vec%0d.count", k), 32'(edge_count), 32'(vecs[k].cnt));
            chk($sformatf("vec%0d.err", k), 32'(err_bad_edge), 32'(vecs[k].err));
`ifdef DEGREE_COUNT_EN
            if (k == 0) chk("vec0.degree", 32'(degree), 32'({5'd2, 5'd2, 5'd2}));
`endif
            ack_hold();
        end

        // edge_valid toggling every cycle; ready must stay high through LOAD
        model_clear();
        pulse_start();
        send(0, 1, 1'b0, 1);
        send(1, 2, 1'b0, 1);
        send(0, 2, 1'b1, 0);
        chk("toggle.adj", 32'(adj_matrix), 32'(9'b011_101_110));
        check_model("toggle", 1'b1);

        // long hold with ignored start, then ack and a clearing start
        for (int c = 0; c < 10; c++) begin
            start = (c == 5);
            @(posedge clk); #1;
            check_model($sformatf("hold%0d", c), 1'b1);
        end
        start = 1'b0;
        ack_hold();
        chk("idle_keep.adj", 32'(adj_matrix), 32'(9'b011_101_110));
        model_clear();
        pulse_start();
        check_model("cleared", 1'b0);
        chk("cleared.ready", 32'(edge_ready), 32'd1);
        send(1, 0, 1'b1, 0);
        check_model("after_clear", 1'b1);
        ack_hold();

        // asynchronous reset in the middle of a load
        model_clear();
        pulse_start();
        send(1, 2, 1'b0, 0);
        check_model("midload", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_model("async_rst", 1'b0);
        chk("async_rst.ready", 32'(edge_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.ready", 32'(edge_ready), 32'd0);

        // randomized loads against the reference model
        for (int t = 0; t < 25; t++) begin
            int ne;
            model_clear();
            pulse_start();
            ne = $urandom_range(1, 6);
            for (int e = 0; e < ne; e++) begin
                int u, v;
                u = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 2);
                v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 2);
                send(u, v, e == ne - 1, (e == ne - 1) ? 0 : $urandom_range(0, 2));
            end
            check_model($sformatf("rnd%0d", t), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check_model($sformatf("rnd%0d.hold", t), 1'b1);
            ack_hold();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
